// File: rtl/leb128_pkg.sv
// Shared constants and types for the 32-bit LEB128 encoder and byte serializer.
package leb128_pkg;

  localparam int LEB128_MAX_BYTES = 5;
  localparam int LEB128_PACKED_W  = 8 * LEB128_MAX_BYTES;
  localparam int LEB128_LEN_W     = 3;

  typedef enum logic [0:0] {
    SER_IDLE = 1'b0,
    SER_SEND = 1'b1
  } ser_state_t;

endpackage

// File: rtl/leb128_byte_serializer.sv
// Serializes one packed LEB128 word per handshake into a byte stream, LSB byte first, with end-of-word marker.
// Optional macro LEB128_SER_CHECK_EN adds a sticky len_err output and an assertion on illegal in_len.
//
// state    | meaning
// SER_IDLE | no word held, in_ready high
// SER_SEND | word held in r_shreg, r_remaining >= 1 bytes still to emit
module leb128_byte_serializer
  import leb128_pkg::*;
#(
  parameter int MAX_BYTES = LEB128_MAX_BYTES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LEB128_PACKED_W-1:0] in_packed,
  input  logic [LEB128_LEN_W-1:0]    in_len,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [7:0]                 out_data,
`ifdef LEB128_SER_CHECK_EN
  output logic                       len_err,
`endif
  output logic                       out_last
);

  localparam logic [LEB128_LEN_W-1:0] MaxLen = LEB128_LEN_W'(MAX_BYTES);

  ser_state_t                 r_state;
  logic [LEB128_PACKED_W-1:0] r_shreg;
  logic [LEB128_LEN_W-1:0]    r_remaining;

  logic                    w_accept;
  logic                    w_byte_hs;
  logic [LEB128_LEN_W-1:0] w_eff_len;

  assign out_valid = (r_state == SER_SEND);
  assign out_data  = r_shreg[7:0];
  assign out_last  = (r_remaining == LEB128_LEN_W'(1));

  // Accepting on the last-byte handshake is what keeps back-to-back words bubble-free.
  assign in_ready  = (r_state == SER_IDLE) | (out_valid & out_ready & out_last);
  assign w_accept  = in_valid & in_ready;
  assign w_byte_hs = out_valid & out_ready;

  always_comb begin
    w_eff_len = in_len;
    if (in_len == '0)
      w_eff_len = LEB128_LEN_W'(1);
    else if (in_len > MaxLen)
      w_eff_len = MaxLen;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SER_IDLE;
      r_shreg     <= '0;
      r_remaining <= '0;
    end else if (w_accept) begin
      r_state     <= SER_SEND;
      r_shreg     <= in_packed;
      r_remaining <= w_eff_len;
    end else if (w_byte_hs) begin
      if (r_remaining > LEB128_LEN_W'(1)) begin
        r_shreg     <= r_shreg >> 8;
        r_remaining <= r_remaining - LEB128_LEN_W'(1);
      end else begin
        r_state     <= SER_IDLE;
        r_remaining <= '0;
      end
    end
  end

`ifdef LEB128_SER_CHECK_EN
  logic r_len_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_len_err <= 1'b0;
    else if (w_accept && ((in_len == '0) || (in_len > MaxLen)))
      r_len_err <= 1'b1;
  end

  assign len_err = r_len_err;

  a_len_legal : assert property (@(posedge clk) disable iff (!rst_n)
    w_accept |-> ((in_len != '0) && (in_len <= MaxLen)));
`endif

endmodule

// File: tb/tb_leb128_byte_serializer.sv
// Directed self-checking bench for leb128_byte_serializer (default build).
module tb_leb128_byte_serializer;
  import leb128_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] in_packed;
  logic [2:0]  in_len;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic        out_last;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  leb128_byte_serializer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_packed (in_packed),
    .in_len    (in_len),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Presents a word at a negedge; returns at the next negedge with the first byte visible.
  task automatic send_word(input string tag, input logic [39:0] packed_w, input logic [2:0] len);
    in_valid  = 1'b1;
    in_packed = packed_w;
    in_len    = len;
    #1 chk({tag, "_in_ready"}, 40'(in_ready), 40'd1);
    @(negedge clk);
    in_valid  = 1'b0;
    in_packed = 40'hDEAD_BEEF_00;
    in_len    = 3'd3;
  endtask

  task automatic expect_byte(input string tag, input logic [7:0] data, input logic last);
    chk({tag, "_valid"}, 40'(out_valid), 40'd1);
    chk({tag, "_data"},  40'(out_data),  40'(data));
    chk({tag, "_last"},  40'(out_last),  40'(last));
    @(negedge clk);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_packed = '0;
    in_len    = 3'd0;
    out_ready = 1'b1;
    #12;
    chk("rst_valid",    40'(out_valid), 40'd0);
    chk("rst_data",     40'(out_data),  40'd0);
    chk("rst_last",     40'(out_last),  40'd0);
    chk("rst_in_ready", 40'(in_ready),  40'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 127: single byte, in_ready high alongside the last byte
    send_word("v127", 40'h00_0000_007F, 3'd1);
    chk("v127_ready_at_last", 40'(in_ready), 40'd1);
    expect_byte("v127_b0", 8'h7F, 1'b1);
    chk("v127_idle", 40'(out_valid), 40'd0);

    // 300: two bytes
    send_word("v300", 40'h00_0000_02AC, 3'd2);
    chk("v300_ready_mid", 40'(in_ready), 40'd0);
    expect_byte("v300_b0", 8'hAC, 1'b0);
    expect_byte("v300_b1", 8'h02, 1'b1);
    chk("v300_idle", 40'(out_valid), 40'd0);

    // 0xFFFFFFFF with a 3-cycle stall after byte 2
    send_word("vmax", 40'h0F_FFFF_FFFF, 3'd5);
    expect_byte("vmax_b0", 8'hFF, 1'b0);
    expect_byte("vmax_b1", 8'hFF, 1'b0);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("vmax_stall_valid", 40'(out_valid), 40'd1);
      chk("vmax_stall_data",  40'(out_data),  40'hFF);
      chk("vmax_stall_last",  40'(out_last),  40'd0);
      chk("vmax_stall_ready", 40'(in_ready),  40'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    expect_byte("vmax_b2", 8'hFF, 1'b0);
    expect_byte("vmax_b3", 8'hFF, 1'b0);
    expect_byte("vmax_b4", 8'h0F, 1'b1);
    chk("vmax_idle", 40'(out_valid), 40'd0);

    // Back-to-back: 0x02AC (len 2) then 0x05 (len 1), in_valid held
    in_valid  = 1'b1;
    in_packed = 40'h00_0000_02AC;
    in_len    = 3'd2;
    @(negedge clk);
    in_packed = 40'h00_0000_0005;
    in_len    = 3'd1;
    #1 chk("b2b_ready_mid", 40'(in_ready), 40'd0);
    expect_byte("b2b_b0", 8'hAC, 1'b0);
    #1 chk("b2b_ready_last", 40'(in_ready), 40'd1);
    expect_byte("b2b_b1", 8'h02, 1'b1);
    in_valid = 1'b0;
    expect_byte("b2b_b2", 8'h05, 1'b1);
    chk("b2b_idle", 40'(out_valid), 40'd0);

    // Length clamping
    send_word("len0", 40'hAA_BBCC_DD55, 3'd0);
    expect_byte("len0_b0", 8'h55, 1'b1);
    chk("len0_idle", 40'(out_valid), 40'd0);
    send_word("len7", 40'h01_0203_0405, 3'd7);
    expect_byte("len7_b0", 8'h05, 1'b0);
    expect_byte("len7_b1", 8'h04, 1'b0);
    expect_byte("len7_b2", 8'h03, 1'b0);
    expect_byte("len7_b3", 8'h02, 1'b0);
    expect_byte("len7_b4", 8'h01, 1'b1);
    chk("len7_idle", 40'(out_valid), 40'd0);

    // Reset in the middle of a 5-byte word
    send_word("rmid", 40'h11_2233_4455, 3'd5);
    expect_byte("rmid_b0", 8'h55, 1'b0);
    chk("rmid_b1_data", 40'(out_data), 40'h44);
    rst_n = 1'b0;
    #1;
    chk("rmid_async_valid", 40'(out_valid), 40'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rmid_post_ready", 40'(in_ready),  40'd1);
    chk("rmid_post_valid", 40'(out_valid), 40'd0);
    send_word("fresh", 40'h00_0000_02AC, 3'd2);
    expect_byte("fresh_b0", 8'hAC, 1'b0);
    expect_byte("fresh_b1", 8'h02, 1'b1);
    chk("fresh_idle", 40'(out_valid), 40'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
